// File: rtl/alu_rs_scheduler_if.sv
// Dispatch, CDB snoop and ALU issue bundle for the ALU reservation station.
// master = dispatch/CDB/ALU side, slave = the scheduler itself.
interface alu_rs_scheduler_if #(
  parameter int ROB_W = 4
);
  logic             disp_valid;
  logic [2:0]       disp_op;
  logic             disp_op_addition;
  logic             disp_has_imm;
  logic [4:0]       disp_imm;
  logic [31:0]      disp_vi;
  logic [31:0]      disp_vj;
  logic             disp_qi_wait;
  logic             disp_qj_wait;
  logic [ROB_W-1:0] disp_qi;
  logic [ROB_W-1:0] disp_qj;
  logic [ROB_W-1:0] disp_rob_entry;

  logic             cdb0_valid;
  logic [ROB_W-1:0] cdb0_tag;
  logic [31:0]      cdb0_value;
  logic             cdb1_valid;
  logic [ROB_W-1:0] cdb1_tag;
  logic [31:0]      cdb1_value;

  logic             full_out;
  logic             issue_new;
  logic [31:0]      issue_vi;
  logic [31:0]      issue_vj;
  logic [4:0]       issue_imm;
  logic [2:0]       issue_op;
  logic             issue_has_imm;
  logic             issue_op_addition;
  logic [ROB_W-1:0] issue_rob_entry;

  modport master (
    output disp_valid, disp_op, disp_op_addition, disp_has_imm, disp_imm,
           disp_vi, disp_vj, disp_qi_wait, disp_qj_wait, disp_qi, disp_qj,
           disp_rob_entry,
           cdb0_valid, cdb0_tag, cdb0_value, cdb1_valid, cdb1_tag, cdb1_value,
    input  full_out, issue_new, issue_vi, issue_vj, issue_imm, issue_op,
           issue_has_imm, issue_op_addition, issue_rob_entry
  );

  modport slave (
    input  disp_valid, disp_op, disp_op_addition, disp_has_imm, disp_imm,
           disp_vi, disp_vj, disp_qi_wait, disp_qj_wait, disp_qi, disp_qj,
           disp_rob_entry,
           cdb0_valid, cdb0_tag, cdb0_value, cdb1_valid, cdb1_tag, cdb1_value,
    output full_out, issue_new, issue_vi, issue_vj, issue_imm, issue_op,
           issue_has_imm, issue_op_addition, issue_rob_entry
  );
endinterface

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: buffers dispatched ops, snoops two CDBs, issues one ready op per cycle.
// Define RS_OLDEST_FIRST_EN for age-matrix oldest-first select; default is lowest-index select.
module alu_rs_scheduler #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = 4
) (
  input logic               clk_in,
  input logic               rst_in,
  input logic               rdy_in,
  input logic               flush_in,
  alu_rs_scheduler_if.slave rs
);
  localparam int IDX_W = $clog2(RS_SIZE);

  typedef struct packed {
    logic [2:0]       op;
    logic             op_addition;
    logic             has_imm;
    logic [4:0]       imm;
    logic [31:0]      vi;
    logic [31:0]      vj;
    logic [ROB_W-1:0] rob_entry;
  } payload_t;

  logic [RS_SIZE-1:0] valid_q, wait_i_q, wait_j_q;
  logic [RS_SIZE-1:0] valid_d, wait_i_d, wait_j_d;
  payload_t           ent_q [RS_SIZE];
  payload_t           ent_d [RS_SIZE];
  logic [ROB_W-1:0]   qi_q  [RS_SIZE];
  logic [ROB_W-1:0]   qj_q  [RS_SIZE];

  payload_t           issue_q;
  logic               issue_new_q;

  logic [RS_SIZE-1:0] ready;
  logic [IDX_W-1:0]   free_idx, sel_idx;
  logic               free_found, sel_found;
  logic               full;
  logic               disp_fire;
  logic               disp_wait_i, disp_wait_j;
  logic [31:0]        disp_vi, disp_vj;

`ifdef RS_OLDEST_FIRST_EN
  // age_q[i][j] set means entry j is older than entry i
  logic [RS_SIZE-1:0] age_q [RS_SIZE];
  logic [RS_SIZE-1:0] age_d [RS_SIZE];
`endif

  assign ready     = valid_q & ~wait_i_q & ~wait_j_q;
  assign full      = &valid_q;
  assign disp_fire = rs.disp_valid && !full;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
`ifdef RS_OLDEST_FIRST_EN
      if (ready[i] && ((age_q[i] & ready) == '0) && !sel_found) begin
`else
      if (ready[i] && !sel_found) begin
`endif
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Dispatch bypass: a tag broadcast this cycle is captured directly, cdb0 first.
  always_comb begin
    disp_wait_i = rs.disp_qi_wait;
    disp_vi     = rs.disp_vi;
    disp_wait_j = rs.disp_qj_wait;
    disp_vj     = rs.disp_vj;
    if (rs.disp_qi_wait) begin
      if (rs.cdb0_valid && rs.cdb0_tag == rs.disp_qi) begin
        disp_wait_i = 1'b0;
        disp_vi     = rs.cdb0_value;
      end else if (rs.cdb1_valid && rs.cdb1_tag == rs.disp_qi) begin
        disp_wait_i = 1'b0;
        disp_vi     = rs.cdb1_value;
      end
    end
    if (rs.disp_qj_wait) begin
      if (rs.cdb0_valid && rs.cdb0_tag == rs.disp_qj) begin
        disp_wait_j = 1'b0;
        disp_vj     = rs.cdb0_value;
      end else if (rs.cdb1_valid && rs.cdb1_tag == rs.disp_qj) begin
        disp_wait_j = 1'b0;
        disp_vj     = rs.cdb1_value;
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    wait_i_d = wait_i_q;
    wait_j_d = wait_j_q;
    ent_d    = ent_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (valid_q[i] && wait_i_q[i]) begin
        if (rs.cdb0_valid && rs.cdb0_tag == qi_q[i]) begin
          wait_i_d[i] = 1'b0;
          ent_d[i].vi = rs.cdb0_value;
        end else if (rs.cdb1_valid && rs.cdb1_tag == qi_q[i]) begin
          wait_i_d[i] = 1'b0;
          ent_d[i].vi = rs.cdb1_value;
        end
      end
      if (valid_q[i] && wait_j_q[i]) begin
        if (rs.cdb0_valid && rs.cdb0_tag == qj_q[i]) begin
          wait_j_d[i] = 1'b0;
          ent_d[i].vj = rs.cdb0_value;
        end else if (rs.cdb1_valid && rs.cdb1_tag == qj_q[i]) begin
          wait_j_d[i] = 1'b0;
          ent_d[i].vj = rs.cdb1_value;
        end
      end
    end
    if (sel_found) valid_d[sel_idx] = 1'b0;
    // The free slot is never the selected one, so issue and dispatch cannot collide.
    if (disp_fire) begin
      valid_d[free_idx]  = 1'b1;
      wait_i_d[free_idx] = disp_wait_i;
      wait_j_d[free_idx] = disp_wait_j;
      ent_d[free_idx]    = '{op:          rs.disp_op,
                             op_addition: rs.disp_op_addition,
                             has_imm:     rs.disp_has_imm,
                             imm:         rs.disp_imm,
                             vi:          disp_vi,
                             vj:          disp_vj,
                             rob_entry:   rs.disp_rob_entry};
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  always_comb begin
    age_d = age_q;
    if (sel_found) begin
      for (int r = 0; r < RS_SIZE; r++) age_d[r][sel_idx] = 1'b0;
    end
    if (disp_fire) age_d[free_idx] = valid_q & ~(RS_SIZE'(sel_found) << sel_idx);
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      // NOTE: only control state is reset; entry payloads are qualified by valid and never read stale.
      valid_q     <= '0;
      issue_new_q <= 1'b0;
      issue_q     <= '0;
`ifdef RS_OLDEST_FIRST_EN
      age_q       <= '{default: '0};
`endif
    end else if (rdy_in) begin
      if (flush_in) begin
        valid_q     <= '0;
        issue_new_q <= 1'b0;
`ifdef RS_OLDEST_FIRST_EN
        age_q       <= '{default: '0};
`endif
      end else begin
        valid_q     <= valid_d;
        wait_i_q    <= wait_i_d;
        wait_j_q    <= wait_j_d;
        ent_q       <= ent_d;
        issue_new_q <= sel_found;
        if (sel_found) issue_q <= ent_q[sel_idx];
        if (disp_fire) begin
          qi_q[free_idx] <= rs.disp_qi;
          qj_q[free_idx] <= rs.disp_qj;
        end
`ifdef RS_OLDEST_FIRST_EN
        age_q       <= age_d;
`endif
      end
    end
  end

  assign rs.full_out          = full;
  assign rs.issue_new         = issue_new_q;
  assign rs.issue_vi          = issue_q.vi;
  assign rs.issue_vj          = issue_q.vj;
  assign rs.issue_imm         = issue_q.imm;
  assign rs.issue_op          = issue_q.op;
  assign rs.issue_has_imm     = issue_q.has_imm;
  assign rs.issue_op_addition = issue_q.op_addition;
  assign rs.issue_rob_entry   = issue_q.rob_entry;
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed self-checking bench for alu_rs_scheduler (RS_SIZE=8, ROB_W=4).
// Expected values are hand-derived; select-order expectations follow RS_OLDEST_FIRST_EN.
module tb_alu_rs_scheduler;
  localparam int ROB_W = 4;

`ifdef RS_OLDEST_FIRST_EN
  localparam logic [3:0] FIRST_ROB  = 4'd1;
  localparam logic [3:0] SECOND_ROB = 4'd2;
`else
  localparam logic [3:0] FIRST_ROB  = 4'd2;
  localparam logic [3:0] SECOND_ROB = 4'd1;
`endif

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, flush_in;
  int   checks   = 0;
  int   failures = 0;

  alu_rs_scheduler_if #(.ROB_W(ROB_W)) bus ();

  alu_rs_scheduler #(.RS_SIZE(8), .ROB_W(ROB_W)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush_in (flush_in),
    .rs       (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge; inputs change at the same point.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
    bus.cdb0_valid = 1'b0;
    bus.cdb1_valid = 1'b0;
    flush_in       = 1'b0;
  endtask

  task automatic disp(input logic [3:0] rob, input logic [31:0] vi, input logic [31:0] vj,
                      input logic wi, input logic [3:0] qi, input logic wj, input logic [3:0] qj);
    bus.disp_valid       = 1'b1;
    bus.disp_op          = 3'd0;
    bus.disp_op_addition = 1'b0;
    bus.disp_has_imm     = 1'b0;
    bus.disp_imm         = 5'd0;
    bus.disp_vi          = vi;
    bus.disp_vj          = vj;
    bus.disp_qi_wait     = wi;
    bus.disp_qi          = qi;
    bus.disp_qj_wait     = wj;
    bus.disp_qj          = qj;
    bus.disp_rob_entry   = rob;
  endtask

  task automatic cdb0(input logic [3:0] tag, input logic [31:0] value);
    bus.cdb0_valid = 1'b1;
    bus.cdb0_tag   = tag;
    bus.cdb0_value = value;
  endtask

  task automatic cdb1(input logic [3:0] tag, input logic [31:0] value);
    bus.cdb1_valid = 1'b1;
    bus.cdb1_tag   = tag;
    bus.cdb1_value = value;
  endtask

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    idle();
    disp(0, 0, 0, 0, 0, 0, 0);
    bus.disp_valid = 1'b0;
    cdb0(0, 0); cdb1(0, 0);
    idle();

    // Reset held two cycles
    step(); step();
    check("rst_full", 32'(bus.full_out), 0);
    check("rst_issue_new", 32'(bus.issue_new), 0);
    check("rst_issue_vi", bus.issue_vi, 0);
    check("rst_issue_rob", 32'(bus.issue_rob_entry), 0);
    rst_in = 1'b1;

    // Simple ADD, ready operands
    disp(1, 5, 7, 0, 0, 0, 0);
    step(); idle();
    check("add_not_early", 32'(bus.issue_new), 0);
    step();
    check("add_issue_new", 32'(bus.issue_new), 1);
    check("add_vi", bus.issue_vi, 5);
    check("add_vj", bus.issue_vj, 7);
    check("add_op", 32'(bus.issue_op), 0);
    check("add_rob", 32'(bus.issue_rob_entry), 1);

    // Immediate op fields pass through
    disp(2, 32'h80, 0, 0, 0, 0, 0);
    bus.disp_op = 3'd5; bus.disp_op_addition = 1'b1;
    bus.disp_has_imm = 1'b1; bus.disp_imm = 5'd3;
    step(); idle();
    check("add_pulse_end", 32'(bus.issue_new), 0);
    check("add_vi_hold", bus.issue_vi, 5);
    step();
    check("imm_issue_new", 32'(bus.issue_new), 1);
    check("imm_op", 32'(bus.issue_op), 5);
    check("imm_op_add", 32'(bus.issue_op_addition), 1);
    check("imm_has_imm", 32'(bus.issue_has_imm), 1);
    check("imm_imm", 32'(bus.issue_imm), 3);
    check("imm_vi", bus.issue_vi, 32'h80);
    step();

    // Fill all eight entries waiting on tag 3
    for (int i = 0; i < 8; i++) begin
      disp(4'(i), 0, 32'(i), 1, 3, 0, 0);
      step(); idle();
      if (i == 6) check("fill_not_full_7", 32'(bus.full_out), 0);
    end
    check("fill_full", 32'(bus.full_out), 1);
    disp(15, 32'h99, 0, 0, 0, 0, 0);
    step(); idle();
    check("ninth_full", 32'(bus.full_out), 1);
    check("ninth_no_issue", 32'(bus.issue_new), 0);
    cdb0(3, 32'h10);
    step(); idle();
    check("wake_not_early", 32'(bus.issue_new), 0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("burst_new", 32'(bus.issue_new), 1);
      check("burst_vi", bus.issue_vi, 32'h10);
      check("burst_vj", bus.issue_vj, 32'(k));
      check("burst_rob", 32'(bus.issue_rob_entry), 32'(k));
      if (k == 0) check("burst_full_drop", 32'(bus.full_out), 0);
    end
    step();
    check("burst_done", 32'(bus.issue_new), 0);

    // Dispatch bypass from cdb1, then cdb0 priority on a double match
    disp(5, 1, 0, 0, 0, 1, 6);
    cdb1(6, 32'hDEAD);
    step(); idle();
    step();
    check("byp_new", 32'(bus.issue_new), 1);
    check("byp_vj", bus.issue_vj, 32'hDEAD);
    check("byp_vi", bus.issue_vi, 1);
    check("byp_rob", 32'(bus.issue_rob_entry), 5);
    disp(6, 0, 2, 1, 7, 0, 0);
    cdb0(7, 32'hAAAA);
    cdb1(7, 32'hBBBB);
    step(); idle();
    step();
    check("byp_prio_vi", bus.issue_vi, 32'hAAAA);
    check("byp_prio_rob", 32'(bus.issue_rob_entry), 6);
    step();

    // Wake B before A: B issues first
    disp(1, 0, 0, 1, 8, 0, 0); step();
    disp(2, 0, 0, 1, 9, 0, 0); step(); idle();
    cdb0(9, 32'h22); step(); idle();
    check("order_wait", 32'(bus.issue_new), 0);
    step();
    check("order_b_new", 32'(bus.issue_new), 1);
    check("order_b_rob", 32'(bus.issue_rob_entry), 2);
    check("order_b_vi", bus.issue_vi, 32'h22);
    cdb0(8, 32'h11); step(); idle();
    check("order_gap", 32'(bus.issue_new), 0);
    step();
    check("order_a_rob", 32'(bus.issue_rob_entry), 1);
    check("order_a_vi", bus.issue_vi, 32'h11);
    step();

    // Both wake together; A (rob 1) sits in index 1, B (rob 2) in index 0
    disp(3, 0, 0, 0, 0, 0, 0); step();
    disp(1, 0, 0, 1, 10, 0, 0); step();
    check("age_x_rob", 32'(bus.issue_rob_entry), 3);
    disp(2, 0, 0, 1, 10, 0, 0); step(); idle();
    cdb0(10, 32'h33); step(); idle();
    step();
    check("age_first_new", 32'(bus.issue_new), 1);
    check("age_first_rob", 32'(bus.issue_rob_entry), 32'(FIRST_ROB));
    step();
    check("age_second_new", 32'(bus.issue_new), 1);
    check("age_second_rob", 32'(bus.issue_rob_entry), 32'(SECOND_ROB));
    step();

    // Flush with coincident dispatch and CDB match
    for (int i = 0; i < 3; i++) begin
      disp(4'(4 + i), 0, 0, 1, 11, 0, 0); step(); idle();
    end
    flush_in = 1'b1;
    disp(7, 1, 1, 0, 0, 0, 0);
    cdb0(11, 32'h55);
    step(); idle();
    check("flush_full", 32'(bus.full_out), 0);
    check("flush_new", 32'(bus.issue_new), 0);
    cdb0(11, 32'h66); step(); idle();
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_quiet", 32'(bus.issue_new), 0);
    end
    for (int i = 0; i < 8; i++) begin
      disp(4'(i), 0, 0, 1, 12, 0, 0); step(); idle();
      check("flush_refill_full", 32'(bus.full_out), (i == 7) ? 1 : 0);
    end
    flush_in = 1'b1; step(); idle();
    check("flush2_full", 32'(bus.full_out), 0);

    // rdy_in stall holds the pending issue and blocks dispatch
    disp(8, 32'h44, 0, 0, 0, 0, 0); step();
    disp(9, 32'h45, 0, 0, 0, 0, 0); step(); idle();
    check("stall_pre_new", 32'(bus.issue_new), 1);
    check("stall_pre_rob", 32'(bus.issue_rob_entry), 8);
    rdy_in = 1'b0;
    disp(10, 32'h46, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_new", 32'(bus.issue_new), 1);
      check("stall_rob", 32'(bus.issue_rob_entry), 8);
    end
    rdy_in = 1'b1; idle();
    step();
    check("resume_new", 32'(bus.issue_new), 1);
    check("resume_rob", 32'(bus.issue_rob_entry), 9);
    check("resume_vi", bus.issue_vi, 32'h45);
    step();
    check("resume_done", 32'(bus.issue_new), 0);

    // Reset mid-operation discards a ready entry
    disp(12, 32'h77, 0, 0, 0, 0, 0); step(); idle();
    rst_in = 1'b0; step(); rst_in = 1'b1;
    check("midrst_new", 32'(bus.issue_new), 0);
    check("midrst_rob", 32'(bus.issue_rob_entry), 0);
    check("midrst_vi", bus.issue_vi, 0);
    check("midrst_full", 32'(bus.full_out), 0);
    step();
    check("midrst_no_issue", 32'(bus.issue_new), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_rs_scheduler.md
# alu_rs_scheduler

Reservation station and issue scheduler for the common integer ALU. It buffers up to RS_SIZE dispatched ALU operations and snoops two common-data-bus (CDB) result ports to capture pending source operands. Each cycle it issues at most one operand-complete operation to the ALU as a registered one-cycle `issue_new` pulse. It sits between the decoder/dispatch stage and the ALU; the ROB drives the flush.

## Interface
Parameters:
- RS_SIZE, 8, number of station entries (power of two, ≥2)
- ROB_W, 4, width of ROB tags; equals the global ROB index width

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset; one clock; reset is synchronous and active-low
- rdy_in  in  1  global ready; low = freeze all state and outputs
- flush_in  in  1  misprediction flush; drops all entries
- disp_valid  in  1  dispatch request
- disp_op  in  3  ALU funct3
- disp_op_addition  in  1  sub/sra select
- disp_has_imm  in  1  second operand is immediate
- disp_imm  in  5  immediate field passed to ALU
- disp_vi, disp_vj  in  32  operand values (meaningful when not waiting)
- disp_qi_wait, disp_qj_wait  in  1  operand waits on a tag
- disp_qi, disp_qj  in  ROB_W  producer ROB tags
- disp_rob_entry  in  ROB_W  destination ROB tag
- cdb0_valid, cdb1_valid  in  1  result broadcast valid (0 = ALU, 1 = LSB)
- cdb0_tag, cdb1_tag  in  ROB_W  broadcast tag
- cdb0_value, cdb1_value  in  32  broadcast value
- full_out  out  1  no free entry
- issue_new  out  1  one-cycle issue strobe to ALU
- issue_vi, issue_vj  out  32  operands
- issue_imm  out  5; issue_op  out  3; issue_has_imm  out  1; issue_op_addition  out  1
- issue_rob_entry  out  ROB_W  destination tag

## Operation
- Per entry: valid, op fields, vi/vj, qi/qj, wait_i/wait_j, rob_entry.
- Allocation: a dispatch is accepted when `disp_valid && !full_out`. The request is written into the lowest-index free entry. A dispatch while `full_out` is high is ignored; the dispatcher must hold the request.
- Dispatch bypass: if a waiting source tag matches a valid CDB in the same cycle, the entry is written with the CDB value and is not waiting. cdb0 has priority if both CDBs match.
- Wakeup: each valid entry compares wait_i/wait_j tags against both CDBs every cycle. On a match it captures the value and clears the wait flag.
- `has_imm` entries ignore the j operand; the dispatcher drives `disp_qj_wait = 0` for them.
- Ready: valid && !wait_i && !wait_j. Readiness is computed from registered state only, so a CDB-woken entry becomes eligible the following cycle.
- Select: exactly one ready entry per cycle, chosen by the policy in Configuration. The chosen entry is freed at the edge and its fields are registered onto the issue_* outputs with `issue_new = 1`.
- If no entry is ready, `issue_new = 0` and the other issue_* outputs hold their previous values.
- `full_out = (occupancy == RS_SIZE)`, derived from registered valid bits. Same-edge issue plus dispatch at full is therefore refused.
- Flush: all valid bits are cleared and `issue_new = 0` at the next edge. Flush overrides same-cycle dispatch, wakeup and issue.
- Priority order per edge: reset > rdy_in low (hold) > flush > {issue, wakeup, dispatch} in parallel.

## Timing
- Reset (rst_in low at edge): all entries invalid, all issue_* = 0, issue_new = 0, full_out = 0.
- Dispatch with ready operands at edge t → issue_new high after edge t+1 (earliest) → ALU result valid after edge t+2.
- CDB wakeup at edge t → issue_new high after edge t+1 earliest.
- Back-to-back: one issue per cycle sustained while ready entries exist.
- rdy_in low: nothing changes, and issue_new holds its value. The ALU also stalls, so an issue pending at the stall is consumed when rdy_in returns high.
- Reset mid-operation discards all entries with no issue.

## Configuration
- `RS_OLDEST_FIRST_EN` defined: an RS_SIZE×RS_SIZE age matrix is maintained. The row is set on allocation; the column is cleared on free and on flush. The selector issues the oldest ready entry.
- Not defined: the selector issues the lowest-index ready entry. No age storage is built.

## Test plan
- Reset with rst_in=0 for 2 cycles → full_out=0, issue_new=0, issue_vi=0; after release, dispatch ADD vi=5 vj=7 with no waits → issue_new pulse 1 cycle, issue_vi=5, issue_vj=7, issue_op=0.
- Fill 8 entries all waiting on tag 3; 9th dispatch → full_out=1 and 9th not stored. cdb0 tag 3 value 0x10 → 8 consecutive issue_new pulses, all vi=0x10; full_out drops after the first issue.
- Dispatch in the same cycle as cdb1_valid with tag 6, value 0xDEAD, while the dispatch waits on qj=6 → issue next cycle with vj=0xDEAD.
- Dispatch A (rob 1) and B (rob 2) waiting, then wake B before A → B issues first. With both ready the same cycle and RS_OLDEST_FIRST_EN, rob 1 issues first even when A sits in the higher index.
- Three waiting entries, then flush_in=1 coincident with dispatch and a CDB match → zero entries remain, no issue_new ever pulses, full_out=0.
- Ready entry present, rdy_in=0 for 3 cycles → issue_new and issue_rob_entry unchanged and no new entry consumed; issue resumes on the first cycle after rdy_in=1.
